// File: rtl/isr_seq_pkg.sv
// Shared types and default parameters for the integer square-root request sequencer.
package isr_seq_pkg;

  localparam int unsigned DefaultDepth         = 4;
  localparam int unsigned DefaultTagW          = 4;
  localparam int unsigned DefaultTimeoutCycles = 2048;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait
  } isr_state_e;

  typedef struct packed {
    logic [63:0]            value;
    logic [DefaultTagW-1:0] tag;
  } isr_req_t;

endpackage

// File: rtl/isr_seq_fifo.sv
// Synchronous request FIFO with wrap-around pointers; DEPTH must be a power of two.
module isr_seq_fifo
  import isr_seq_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter type         T     = isr_req_t
) (
  input  logic clock,
  input  logic reset_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/isr_sequencer.sv
// Queues tagged operands and runs them one at a time through the integer square-root unit.
// Optional watchdog: define ISR_TIMEOUT_EN to abort a stuck operation with out_err.
module isr_sequencer
  import isr_seq_pkg::*;
#(
  parameter int unsigned DEPTH          = DefaultDepth,
  parameter int unsigned TAG_W          = DefaultTagW,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_value,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             isr_start,
  output logic [63:0]      isr_value,
  input  logic [31:0]      isr_result,
  input  logic             isr_done,
  output logic             busy
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("isr_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES nonzero");
  end

  typedef struct packed {
    logic [63:0]      value;
    logic [TAG_W-1:0] tag;
  } req_t;

  isr_state_e       state_q, state_d;
  logic [63:0]      op_value_q, op_value_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             fifo_pop, fifo_full, fifo_empty;
  logic             load;
  logic             timeout;
  req_t             fifo_in, fifo_head;

  assign fifo_in = '{value: in_value, tag: in_tag};

  isr_seq_fifo #(
    .DEPTH(DEPTH),
    .T    (req_t)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (in_valid),
    .push_data(fifo_in),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    op_value_d   = op_value_q;
    op_tag_d     = op_tag_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    fifo_pop     = 1'b0;
    load         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          op_value_d = fifo_head.value;
          op_tag_d   = fifo_head.tag;
          state_d    = StStart;
        end
      end
      // isr_done may still be high from the previous result here, so it is not looked at.
      StStart: state_d = StWait;
      StWait: begin
        if ((isr_done || timeout) && (!out_valid_q || out_ready)) begin
          load         = 1'b1;
          out_valid_d  = 1'b1;
          out_result_d = isr_done ? isr_result : 32'd0;
          out_tag_d    = op_tag_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      op_value_q   <= '0;
      op_tag_q     <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      state_q      <= state_d;
      op_value_q   <= op_value_d;
      op_tag_q     <= op_tag_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

`ifdef ISR_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           out_err_q, out_err_d;

  assign timeout = !isr_done && (wd_q == WdW'(TIMEOUT_CYCLES));

  always_comb begin
    wd_d      = wd_q;
    out_err_d = out_err_q;
    if (state_q == StStart) begin
      wd_d = '0;
    end else if (state_q == StWait && wd_q != WdW'(TIMEOUT_CYCLES)) begin
      wd_d = wd_q + 1'b1;
    end
    if (load) out_err_d = !isr_done;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wd_q      <= '0;
      out_err_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      out_err_q <= out_err_d;
    end
  end

  assign out_err = out_err_q;
`else
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

  assign in_ready   = !fifo_full;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  // Hold the root unit in reset for as long as we are.
  assign isr_start  = !reset_n || (state_q == StStart);
  assign isr_value  = op_value_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_isr_sequencer.sv
// Bench for isr_sequencer against a variable-latency behavioural square-root unit.
module tb_isr_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_value = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_err;
  logic        isr_start;
  logic [63:0] isr_value;
  logic [31:0] isr_result;
  logic        isr_done;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  isr_sequencer #(
    .DEPTH         (4),
    .TAG_W         (4),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_tag   (out_tag),
    .out_err   (out_err),
    .isr_start (isr_start),
    .isr_value (isr_value),
    .isr_result(isr_result),
    .isr_done  (isr_done),
    .busy      (busy)
  );

  // Root unit model: restarts while isr_start is high, done after m_lat+1 cycles, holds done.
  logic [63:0] m_val = '0;
  logic [31:0] m_res = '0;
  logic        m_done = 1'b0;
  int          m_cnt = 0;
  int          m_lat = 0;
  bit          m_hang = 1'b0;

  assign isr_done   = m_done;
  assign isr_result = m_res;

  function automatic logic [31:0] isqrt(input logic [63:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= v) r = t;
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (isr_start) begin
      m_val  <= isr_value;
      m_cnt  <= m_lat;
      m_done <= 1'b0;
    end else if (!m_done && !m_hang) begin
      if (m_cnt == 0) begin
        m_done <= 1'b1;
        m_res  <= isqrt(m_val);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  typedef struct {
    logic [63:0] value;
    logic [3:0]  tag;
    logic [31:0] root;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] v, input logic [3:0] t);
    int n;
    n = 0;
    in_value = v;
    in_tag   = t;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("push_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int ticks);
    ticks = 0;
    while (!out_valid && ticks < 300) begin
      tick();
      ticks++;
    end
    check("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int ticks;
    int k;
    int n;
    int seen;

    vecs[0] = '{value: 64'd1_000_000,            tag: 4'd3,  root: 32'd1000,        lat: 3};
    vecs[1] = '{value: 64'd0,                    tag: 4'd0,  root: 32'd0,           lat: 0};
    vecs[2] = '{value: 64'd1,                    tag: 4'd1,  root: 32'd1,           lat: 1};
    vecs[3] = '{value: 64'd2,                    tag: 4'd2,  root: 32'd1,           lat: 5};
    vecs[4] = '{value: 64'hFFFF_FFFF_FFFF_FFFF, tag: 4'd3,  root: 32'hFFFF_FFFF,   lat: 2};
    vecs[5] = '{value: 64'd144,                  tag: 4'd9,  root: 32'd12,          lat: 7};
    vecs[6] = '{value: 64'd15,                   tag: 4'd10, root: 32'd3,           lat: 0};
    vecs[7] = '{value: 64'd16,                   tag: 4'd15, root: 32'd4,           lat: 4};

    // Reset state
    #1;
    check("rst_isr_start", 64'(isr_start), 64'd1);
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    reset_n = 1'b1;
    tick();
    check("idle_isr_start", 64'(isr_start), 64'd0);

    // Single requests: result, tag, no error, latency = lat + 4 cycles after the push edge
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m_lat = vecs[i].lat;
      push(vecs[i].value, vecs[i].tag);
      wait_out(ticks);
      check($sformatf("vec%0d_result", i), 64'(out_result), 64'(vecs[i].root));
      check($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
      check($sformatf("vec%0d_err", i), 64'(out_err), 64'd0);
      check($sformatf("vec%0d_latency", i), 64'(ticks), 64'(vecs[i].lat + 4));
      tick();
      check($sformatf("vec%0d_idle", i), 64'({busy, out_valid}), 64'd0);
    end

    // Back-pressure: six pushes with the consumer stalled, then drain in order
    out_ready = 1'b0;
    m_lat = 1;
    for (int i = 0; i < 6; i++) push(vecs[i].value, vecs[i].tag);
    repeat (10) tick();
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_hold%0d", i), 64'({out_valid, out_tag, out_result}),
            64'({1'b1, vecs[0].tag, vecs[0].root}));
      tick();
    end
    out_ready = 1'b1;
    k = 0;
    n = 0;
    while (k < 6 && n < 200) begin
      if (out_valid) begin
        check($sformatf("drain%0d_result", k), 64'(out_result), 64'(vecs[k].root));
        check($sformatf("drain%0d_tag", k), 64'(out_tag), 64'(vecs[k].tag));
        k++;
      end
      tick();
      n++;
    end
    check("drain_count", 64'(k), 64'd6);
    tick();
    check("drain_idle", 64'({busy, in_ready}), 64'b01);

    // Reset while waiting on the root unit drops the request
    m_lat = 20;
    push(64'd1_000_000, 4'd6);
    repeat (5) tick();
    check("pre_reset_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("reset_isr_start", 64'(isr_start), 64'd1);
    tick();
    reset_n = 1'b1;
    #1;
    check("post_reset_state", 64'({out_valid, busy, in_ready, isr_start}), 64'b0010);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("dropped_no_result", 64'(seen), 64'd0);
    m_lat = 3;
    push(64'd144, 4'd2);
    wait_out(ticks);
    check("after_reset_result", 64'(out_result), 64'd12);
    check("after_reset_tag", 64'(out_tag), 64'd2);
    tick();

    // Stale done still high from the last op must not complete the next one early
    check("stale_done_high", 64'(isr_done), 64'd1);
    m_lat = 8;
    push(64'd49, 4'd5);
    wait_out(ticks);
    check("stale_latency", 64'(ticks), 64'd12);
    check("stale_result", 64'(out_result), 64'd7);
    check("stale_tag", 64'(out_tag), 64'd5);
    tick();

`ifdef ISR_TIMEOUT_EN
    // Watchdog: stuck unit yields an error result, next request recovers
    m_hang = 1'b1;
    push(64'd9, 4'd7);
    wait_out(ticks);
    check("to_latency", 64'(ticks), 64'd67);
    check("to_err", 64'(out_err), 64'd1);
    check("to_result", 64'(out_result), 64'd0);
    check("to_tag", 64'(out_tag), 64'd7);
    tick();
    m_hang = 1'b0;
    m_lat = 2;
    push(64'd144, 4'd1);
    wait_out(ticks);
    check("recover_result", 64'(out_result), 64'd12);
    check("recover_err", 64'(out_err), 64'd0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
